// File: rtl/frame_read_scheduler.sv
// -----------------------------------------------------------------------------
// frame_read_scheduler
//   Frame-level sequencer for the AXI-to-FIFO read engine. Tracks the newest
//   buffer finished by the writer, and on each display vsync programs that
//   buffer's base address into the read engine. It then starts one frame read
//   with a rising edge on rd_blk_en and waits for rd_done, guarded by a
//   watchdog. rd_buf_idx/rd_busy tell the writer which buffer must not be
//   touched.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_enable                 scheduler enable (level)
//   cfg_buf_ba0/1/2            base addresses of the three frame buffers
//   cfg_timeout                watchdog limit in cycles, 0 disables it
//   sts_clr                    pulse: clears sts_timeout/sts_overrun, leaves ERR
//   vsync                      pulse: display requests the next frame
//   wr_frame_done, wr_buf_idx  pulse + index of the buffer the writer completed
//   rd_done                    read engine done flag (level)
//   rd_blk_en, rd_map_ba       start enable and base address to the read engine
//   rd_buf_idx, rd_busy        buffer being/last read, read in progress
//   sts_frame_done             1-cycle pulse per completed frame
//   sts_timeout, sts_overrun   sticky error flags
//   frame_cnt, repeat_cnt      completed frames / frames re-reading a buffer
// -----------------------------------------------------------------------------
module frame_read_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int TO_WIDTH   = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [ADDR_WIDTH-1:0] cfg_buf_ba0,
  input  logic [ADDR_WIDTH-1:0] cfg_buf_ba1,
  input  logic [ADDR_WIDTH-1:0] cfg_buf_ba2,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  input  logic                  sts_clr,
  input  logic                  vsync,
  input  logic                  wr_frame_done,
  input  logic [1:0]            wr_buf_idx,
  input  logic                  rd_done,
  output logic                  rd_blk_en,
  output logic [ADDR_WIDTH-1:0] rd_map_ba,
  output logic [1:0]            rd_buf_idx,
  output logic                  rd_busy,
  output logic                  sts_frame_done,
  output logic                  sts_timeout,
  output logic                  sts_overrun,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  repeat_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VSYNC,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [TO_WIDTH-1:0]  TO_ONE  = TO_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [1:0]           GUARD_MAX = 2'd2;

  state_t                  state, state_d;
  logic [1:0]              latest;
  logic                    new_avail;
  logic                    have_frame;
  logic [TO_WIDTH-1:0]     timer;
  logic [1:0]              guard;
  logic [ADDR_WIDTH-1:0]   sel_ba;
  logic                    wr_valid;
  logic                    done_hit;
  logic                    timeout_hit;
  logic                    overrun_hit;

  // Index 3 from the writer means "no buffer" and is ignored.
  assign wr_valid = wr_frame_done && (wr_buf_idx != 2'd3);

  // The engine's done flag is stale until it has processed the start, so it
  // only counts once guard has seen two RUN cycles.
  assign done_hit    = (state == S_RUN) && rd_done && (guard == GUARD_MAX);
  assign timeout_hit = (state == S_RUN) && (cfg_timeout != '0) &&
                       (timer == cfg_timeout - TO_ONE) && !done_hit;
  assign overrun_hit = vsync && ((state == S_LOAD) || (state == S_RUN) ||
                                 (state == S_DONE));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sel_ba = cfg_buf_ba0;
    unique case (latest)
      2'd1:    sel_ba = cfg_buf_ba1;
      2'd2:    sel_ba = cfg_buf_ba2;
      default: sel_ba = cfg_buf_ba0;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:       if (cfg_enable) state_d = S_WAIT_VSYNC;
      S_WAIT_VSYNC: begin
        if (!cfg_enable)              state_d = S_IDLE;
        else if (vsync && have_frame) state_d = S_LOAD;
      end
      S_LOAD:       state_d = S_RUN;
      S_RUN: begin
        if (done_hit)         state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DONE:       state_d = cfg_enable ? S_WAIT_VSYNC : S_IDLE;
      S_ERR:        if (sts_clr) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      latest         <= 2'd0;
      new_avail      <= 1'b0;
      have_frame     <= 1'b0;
      timer          <= '0;
      guard          <= 2'd0;
      rd_blk_en      <= 1'b0;
      rd_map_ba      <= '0;
      rd_buf_idx     <= 2'd0;
      rd_busy        <= 1'b0;
      sts_frame_done <= 1'b0;
      sts_timeout    <= 1'b0;
      sts_overrun    <= 1'b0;
      frame_cnt      <= '0;
      repeat_cnt     <= '0;
    end else begin
      state <= state_d;

      // Writer tracking; a completion in the LOAD cycle must not be lost,
      // so the set takes priority over the LOAD clear.
      if (wr_valid) begin
        latest     <= wr_buf_idx;
        new_avail  <= 1'b1;
        have_frame <= 1'b1;
      end else if (state == S_LOAD) begin
        new_avail  <= 1'b0;
      end

      if (state == S_LOAD) begin
        rd_map_ba  <= sel_ba;
        rd_buf_idx <= latest;
        timer      <= '0;
        guard      <= 2'd0;
        if (!new_avail) repeat_cnt <= repeat_cnt + CNT_ONE;
      end else if (state == S_RUN) begin
        if (timer != '1)        timer <= timer + TO_ONE;
        if (guard != GUARD_MAX) guard <= guard + 2'd1;
      end

      // Engine enable and busy are high exactly while in RUN.
      rd_blk_en      <= (state_d == S_RUN);
      rd_busy        <= (state_d == S_RUN);
      sts_frame_done <= done_hit;
      if (done_hit) frame_cnt <= frame_cnt + CNT_ONE;

      // Sticky flags: a set in the same cycle as sts_clr wins.
      if (timeout_hit)  sts_timeout <= 1'b1;
      else if (sts_clr) sts_timeout <= 1'b0;
      if (overrun_hit)  sts_overrun <= 1'b1;
      else if (sts_clr) sts_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_read_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_read_scheduler
//   Directed scenarios followed by a randomized phase. A frame-level model
//   predicts every output each cycle from elapsed RUN cycles and the writer
//   bookkeeping; one compare process checks the DUT on every falling edge.
//   Directed scenarios additionally pin key values with literal expectations.
// -----------------------------------------------------------------------------
module tb_frame_read_scheduler;

  localparam int AW = 32;
  localparam int TW = 24;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          cfg_enable;
  logic [AW-1:0] cfg_buf_ba0, cfg_buf_ba1, cfg_buf_ba2;
  logic [TW-1:0] cfg_timeout;
  logic          sts_clr, vsync, wr_frame_done, rd_done;
  logic [1:0]    wr_buf_idx;
  logic          rd_blk_en, rd_busy, sts_frame_done, sts_timeout, sts_overrun;
  logic [AW-1:0] rd_map_ba;
  logic [1:0]    rd_buf_idx;
  logic [CW-1:0] frame_cnt, repeat_cnt;

  frame_read_scheduler #(.ADDR_WIDTH(AW), .TO_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable),
    .cfg_buf_ba0(cfg_buf_ba0), .cfg_buf_ba1(cfg_buf_ba1), .cfg_buf_ba2(cfg_buf_ba2),
    .cfg_timeout(cfg_timeout), .sts_clr(sts_clr), .vsync(vsync),
    .wr_frame_done(wr_frame_done), .wr_buf_idx(wr_buf_idx), .rd_done(rd_done),
    .rd_blk_en(rd_blk_en), .rd_map_ba(rd_map_ba), .rd_buf_idx(rd_buf_idx),
    .rd_busy(rd_busy), .sts_frame_done(sts_frame_done), .sts_timeout(sts_timeout),
    .sts_overrun(sts_overrun), .frame_cnt(frame_cnt), .repeat_cnt(repeat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model. Instead of a state register it tracks what phase of a
  // frame we are in: armed (waiting for vsync), load_now (the load cycle),
  // run_k (RUN cycles already elapsed, -1 when no frame runs), done_now, err.
  // ---------------------------------------------------------------------------
  bit          m_armed, m_load, m_done, m_err;
  int          m_k;
  logic [1:0]  m_latest;
  bit          m_new, m_have;
  logic          e_blk, e_busy, e_fd, e_to, e_ov;
  logic [AW-1:0] e_ba;
  logic [1:0]    e_idx;
  logic [CW-1:0] e_fc, e_rc;

  function automatic logic [AW-1:0] ba_of(input logic [1:0] i);
    if (i == 2'd1) return cfg_buf_ba1;
    if (i == 2'd2) return cfg_buf_ba2;
    return cfg_buf_ba0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit was_load, was_done, was_err, was_armed, wv;
    int k;
    longint tval;
    if (!rst_n) begin
      m_armed = 0; m_load = 0; m_done = 0; m_err = 0; m_k = -1;
      m_latest = 2'd0; m_new = 0; m_have = 0;
      e_blk = 0; e_busy = 0; e_fd = 0; e_to = 0; e_ov = 0;
      e_ba = '0; e_idx = 2'd0; e_fc = '0; e_rc = '0;
    end else begin
      was_load = m_load; was_done = m_done; was_err = m_err; was_armed = m_armed;
      k = m_k;
      wv = wr_frame_done && (wr_buf_idx != 2'd3);
      m_load = 0; m_done = 0;
      e_fd = 0;
      if (sts_clr) begin e_to = 0; e_ov = 0; end
      if (vsync && (was_load || k >= 0 || was_done)) e_ov = 1;
      if (was_load) begin
        e_ba = ba_of(m_latest);
        e_idx = m_latest;
        if (!m_new) e_rc = e_rc + 1'b1;
        m_new = 0;
        m_k = 0;
      end else if (k >= 0) begin
        // Watchdog counter value equals elapsed RUN cycles, saturating.
        tval = (k > 24'hFFFFFF) ? 64'hFFFFFF : longint'(k);
        if (rd_done && k >= 2) begin
          e_fd = 1; e_fc = e_fc + 1'b1; m_k = -1; m_done = 1;
        end else if (cfg_timeout != 0 && tval == longint'(cfg_timeout) - 1) begin
          e_to = 1; m_k = -1; m_err = 1;
        end else begin
          m_k = k + 1;
        end
      end else if (was_done) begin
        m_armed = cfg_enable;
      end else if (was_err) begin
        if (sts_clr) m_err = 0;
      end else if (was_armed) begin
        if (!cfg_enable) m_armed = 0;
        else if (vsync && m_have) begin m_armed = 0; m_load = 1; end
      end else begin
        if (cfg_enable) m_armed = 1;
      end
      if (wv) begin m_latest = wr_buf_idx; m_new = 1; m_have = 1; end
      e_blk = (m_k >= 0);
      e_busy = e_blk;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_rd_blk_en", rd_blk_en, e_blk);
      check("cmp_rd_busy", rd_busy, e_busy);
      check("cmp_rd_map_ba", rd_map_ba, e_ba);
      check("cmp_rd_buf_idx", rd_buf_idx, e_idx);
      check("cmp_sts_frame_done", sts_frame_done, e_fd);
      check("cmp_sts_timeout", sts_timeout, e_to);
      check("cmp_sts_overrun", sts_overrun, e_ov);
      check("cmp_frame_cnt", frame_cnt, e_fc);
      check("cmp_repeat_cnt", repeat_cnt, e_rc);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change right after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr_pulse(input logic [1:0] idx);
    wr_frame_done = 1'b1; wr_buf_idx = idx;
    step();
    wr_frame_done = 1'b0;
  endtask

  // Raise rd_done, wait for the completion pulse, then return in WAIT_VSYNC/IDLE.
  task automatic finish_frame(input string name);
    bit seen;
    seen = 1'b0;
    rd_done = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (sts_frame_done) seen = 1'b1;
    end
    rd_done = 1'b0;
    check({name, "_done_seen"}, seen, 1);
    step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int run;
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_timeout = '0;
    cfg_buf_ba0 = 32'h1000_0000; cfg_buf_ba1 = 32'h2000_0000; cfg_buf_ba2 = 32'h3000_0000;
    sts_clr = 1'b0; vsync = 1'b0; wr_frame_done = 1'b0; wr_buf_idx = 2'd0; rd_done = 1'b0;
    step(); step();
    cmp_en = 1'b1;
    step();
    check("rst_blk_en", rd_blk_en, 0);
    check("rst_map_ba", rd_map_ba, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    cfg_enable = 1'b1;
    cfg_timeout = 24'd1000;
    step(); step();

    // vsync with no completed buffer is dropped.
    vsync = 1'b1; step(); vsync = 1'b0;
    repeat (4) step();
    check("nobuf_blk_en", rd_blk_en, 0);
    check("nobuf_frame_cnt", frame_cnt, 0);
    check("nobuf_repeat_cnt", repeat_cnt, 0);

    // First frame from buffer 1: start two cycles after vsync.
    wr_pulse(2'd1);
    vsync = 1'b1; step(); vsync = 1'b0;
    check("lat_load_blk_en", rd_blk_en, 0);
    step();
    check("lat_run_blk_en", rd_blk_en, 1);
    check("t1_map_ba", rd_map_ba, 32'h2000_0000);
    check("t1_busy", rd_busy, 1);
    finish_frame("t1");
    check("t1_frame_cnt", frame_cnt, 1);

    // Buffer 2 completed, then vsync reads it.
    wr_pulse(2'd2);
    vsync = 1'b1; step(); vsync = 1'b0; step();
    check("t2_map_ba", rd_map_ba, 32'h3000_0000);
    finish_frame("t2");

    // Repeat read of buffer 2; writer completes buffer 0 during LOAD.
    vsync = 1'b1; step(); vsync = 1'b0;
    wr_frame_done = 1'b1; wr_buf_idx = 2'd0; step(); wr_frame_done = 1'b0;
    check("t3_map_ba", rd_map_ba, 32'h3000_0000);
    check("t3_repeat_cnt", repeat_cnt, 1);
    finish_frame("t3a");
    vsync = 1'b1; step(); vsync = 1'b0; step();
    check("t3_new_map_ba", rd_map_ba, 32'h1000_0000);
    check("t3_new_repeat_cnt", repeat_cnt, 1);
    finish_frame("t3b");

    // rd_done stale-high across the start is ignored for the guard window.
    rd_done = 1'b1; vsync = 1'b1; step(); vsync = 1'b0;
    step(); step(); step();
    rd_done = 1'b0;
    check("t4_still_running", rd_blk_en, 1);
    step(); step();
    check("t4_still_running2", rd_blk_en, 1);
    finish_frame("t4");
    check("t4_frame_cnt", frame_cnt, 5);

    // Watchdog: 100 RUN cycles, then ERR until sts_clr.
    cfg_timeout = 24'd100;
    vsync = 1'b1; step(); vsync = 1'b0;
    run = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (rd_blk_en) run++;
      else break;
    end
    check("t5_run_cycles", run, 100);
    check("t5_sts_timeout", sts_timeout, 1);
    vsync = 1'b1; step(); vsync = 1'b0; step();
    check("t5_err_no_start", rd_blk_en, 0);
    check("t5_err_no_overrun", sts_overrun, 0);
    sts_clr = 1'b1; step(); sts_clr = 1'b0;
    check("t5_clr_timeout", sts_timeout, 0);
    step();
    vsync = 1'b1; step(); vsync = 1'b0; step();
    check("t5_restart_blk_en", rd_blk_en, 1);
    finish_frame("t5");
    check("t5_frame_cnt", frame_cnt, 6);

    // Overrun: vsync mid-RUN flags and is not queued.
    cfg_timeout = 24'd1000;
    vsync = 1'b1; step(); vsync = 1'b0; step(); step();
    vsync = 1'b1; step(); vsync = 1'b0;
    check("t6_overrun", sts_overrun, 1);
    finish_frame("t6a");
    repeat (4) step();
    check("t6_no_extra_frame", rd_blk_en, 0);
    check("t6_frame_cnt", frame_cnt, 7);
    sts_clr = 1'b1; step(); sts_clr = 1'b0;
    check("t6_clr_overrun", sts_overrun, 0);

    // Enable dropped mid-RUN: frame completes, then IDLE ignores vsync.
    vsync = 1'b1; step(); vsync = 1'b0; step(); step();
    cfg_enable = 1'b0;
    finish_frame("t6b");
    vsync = 1'b1; step(); vsync = 1'b0;
    repeat (4) step();
    check("t6_idle_no_start", rd_blk_en, 0);
    check("t6_idle_frame_cnt", frame_cnt, 8);

    // Randomized phase, checked cycle by cycle against the model.
    cfg_enable = 1'b1;
    cfg_timeout = 24'd40;
    for (int c = 0; c < 4000; c++) begin
      vsync = ($urandom_range(0, 14) == 0);
      wr_frame_done = ($urandom_range(0, 9) == 0);
      wr_buf_idx = 2'($urandom_range(0, 3));
      sts_clr = ($urandom_range(0, 79) == 0);
      if (cfg_enable) cfg_enable = ($urandom_range(0, 299) != 0);
      else            cfg_enable = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rd_done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0)
        cfg_timeout = ($urandom_range(0, 3) == 0) ? 24'd0 : TW'($urandom_range(3, 60));
      if ($urandom_range(0, 49) == 0) cfg_buf_ba1 = $urandom;
      if ($urandom_range(0, 49) == 0) cfg_buf_ba2 = $urandom;
      step();
    end
    vsync = 1'b0; wr_frame_done = 1'b0; sts_clr = 1'b0; rd_done = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
